// File: rtl/cdb_rr_arbiter.sv
// Common Data Bus round-robin arbiter.
// Grants one execution-unit result per cycle, scanning from a rotating
// pointer, and holds the registered winner on the CDB until the ROB accepts it.
// Build option: define LEN5_CDB_SKID_EN for a 2-entry output FIFO, which
// removes the combinational path from rob_ready_i to eu_ready_o. When it is
// left undefined, a single output register is used.

package cdb_rr_arbiter_pkg;
    localparam int unsigned MAX_EU_N  = 9;
    localparam int unsigned ROB_IDX_W = 6;
    localparam int unsigned VALUE_W   = 32;
    localparam int unsigned EXCEPT_W  = 6;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [VALUE_W-1:0]   res_value;
        logic                 except_raised;
        logic [EXCEPT_W-1:0]  except_code;
    } cdb_data_t;
endpackage

module cdb_rr_arbiter
    import cdb_rr_arbiter_pkg::*;
#(
    parameter int unsigned EU_N = MAX_EU_N
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic [EU_N-1:0] eu_valid_i,
    output logic [EU_N-1:0] eu_ready_o,
    input  cdb_data_t       eu_data_i [EU_N],
    input  logic            rob_ready_i,
    output logic            cdb_valid_o,
    output cdb_data_t       cdb_data_o
);

    localparam int unsigned PTR_W = (EU_N > 1) ? $clog2(EU_N) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(EU_N - 1);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] win_c;
    logic             found_c;
    logic             space_c;
    logic             grant_c;
    int unsigned      scan_idx;

    // Find the first requester at or after the pointer, wrapping explicitly.
    always_comb begin
        found_c  = 1'b0;
        win_c    = '0;
        scan_idx = 0;
        for (int unsigned i = 0; i < EU_N; i++) begin
            scan_idx = 32'(ptr_q) + i;
            if (scan_idx >= EU_N) begin
                scan_idx = scan_idx - EU_N;
            end
            if (!found_c && eu_valid_i[PTR_W'(scan_idx)]) begin
                found_c = 1'b1;
                win_c   = PTR_W'(scan_idx);
            end
        end
    end

    // A grant is a transfer: the winner's valid is high by construction.
    always_comb begin
        grant_c    = space_c && !flush_i && !rst_i && found_c;
        eu_ready_o = grant_c ? (EU_N'(1) << win_c) : '0;
    end

    // Pointer advances past the winner on a transfer; flush leaves it alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (grant_c) begin
            ptr_q <= (win_c == LAST_IDX) ? '0 : win_c + PTR_W'(1);
        end
    end

`ifdef LEN5_CDB_SKID_EN

    cdb_data_t  fifo_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       pop_c;

    // Space comes only from the registered count, never from rob_ready_i.
    always_comb begin
        space_c = (count_q < 2'd2);
        pop_c   = (count_q != 2'd0) && rob_ready_i;
    end

    // Two-entry FIFO; the head drives the CDB.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (grant_c) begin
                fifo_q[wr_ptr_q] <= eu_data_i[win_c];
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_c) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, grant_c} - {1'b0, pop_c};
        end
    end

    always_comb begin
        cdb_valid_o = (count_q != 2'd0);
        cdb_data_o  = fifo_q[rd_ptr_q];
    end

`else

    logic      out_valid_q;
    cdb_data_t out_data_q;

    // The slot is free if empty or being drained this cycle.
    always_comb begin
        space_c = !out_valid_q || rob_ready_i;
    end

    // Single output register that holds its value until the ROB accepts it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (grant_c) begin
            out_valid_q <= 1'b1;
            out_data_q  <= eu_data_i[win_c];
        end else if (rob_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    always_comb begin
        cdb_valid_o = out_valid_q;
        cdb_data_o  = out_data_q;
    end

`endif

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Bench for cdb_rr_arbiter: directed phases plus random traffic, with a
// scoreboard of granted payloads checked in CDB order by a separate monitor.
module tb_cdb_rr_arbiter;
    import cdb_rr_arbiter_pkg::*;

    localparam int unsigned EU_N = 9;
`ifdef LEN5_CDB_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_i = 1'b0;
    logic            flush_i = 1'b0;
    logic [EU_N-1:0] eu_valid_i = '0;
    logic [EU_N-1:0] eu_ready_o;
    cdb_data_t       eu_data_i [EU_N];
    logic            rob_ready_i = 1'b0;
    logic            cdb_valid_o;
    cdb_data_t       cdb_data_o;

    cdb_rr_arbiter #(.EU_N(EU_N)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .eu_valid_i  (eu_valid_i),
        .eu_ready_o  (eu_ready_o),
        .eu_data_i   (eu_data_i),
        .rob_ready_i (rob_ready_i),
        .cdb_valid_o (cdb_valid_o),
        .cdb_data_o  (cdb_data_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: pointer, number of held broadcasts, payloads in order.
    bit        known = 1'b0;
    int        m_ptr = 0;
    int        m_cnt = 0;
    cdb_data_t exp_q[$];

    // Stimulus knobs.
    logic [EU_N-1:0] refill_mask = '0;
    int              refill_pct  = 0;
    int              rdy_pct     = 100;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cdb_data_t rand_data();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[$bits(cdb_data_t)-1:0];
    endfunction

    // One clock: drive inputs, check grant at negedge, update model after posedge.
    task automatic step(input bit rst, input bit flush);
        int              k;
        bit              space;
        logic [EU_N-1:0] exp_rdy;
        rst_i   = rst;
        flush_i = flush;
        for (int e = 0; e < int'(EU_N); e++) begin
            if (!eu_valid_i[e] && refill_mask[e] && ($urandom_range(99) < refill_pct)) begin
                eu_valid_i[e] = 1'b1;
                eu_data_i[e]  = rand_data();
            end
        end
        rob_ready_i = ($urandom_range(99) < rdy_pct);

        @(negedge clk);
        space = SKID ? (m_cnt < 2) : (m_cnt == 0 || rob_ready_i);
        k = -1;
        if (!rst_i && !flush_i && space) begin
            for (int i = 0; i < int'(EU_N); i++) begin
                int idx;
                idx = (m_ptr + i) % int'(EU_N);
                if (k < 0 && eu_valid_i[idx]) k = idx;
            end
        end
        exp_rdy = '0;
        if (k >= 0) exp_rdy[k] = 1'b1;
        chk("eu_ready", 64'(eu_ready_o), 64'(exp_rdy));
        if (known) chk("cdb_valid", 64'(cdb_valid_o), 64'(m_cnt != 0));

        @(posedge clk);
        #1;
        if (rst_i) begin
            known = 1'b1;
            m_ptr = 0;
            m_cnt = 0;
            exp_q.delete();
        end else if (flush_i) begin
            m_cnt = 0;
            exp_q.delete();
        end else begin
            if (m_cnt != 0 && rob_ready_i) m_cnt--;
            if (k >= 0) begin
                m_cnt++;
                exp_q.push_back(eu_data_i[k]);
                m_ptr = (k + 1) % int'(EU_N);
                eu_valid_i[k] = 1'b0;
            end
        end
    endtask

    // Monitor: every visible broadcast must be the oldest outstanding grant.
    always @(negedge clk) begin
        if (known && cdb_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("cdb_unexpected", 64'(cdb_valid_o), 64'(0));
            end else begin
                chk("cdb_data", 64'(cdb_data_o), 64'(exp_q[0]));
                if (rob_ready_i && !flush_i && !rst_i) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        for (int e = 0; e < int'(EU_N); e++) eu_data_i[e] = rand_data();

        // Reset with every EU requesting.
        eu_valid_i  = '1;
        refill_mask = '1;
        refill_pct  = 100;
        rdy_pct     = 100;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        #2;
        chk("rst_data", 64'(cdb_data_o), 64'(0));

        // Full round robin with all EUs requesting.
        for (int i = 0; i < 11; i++) step(1'b0, 1'b0);

        // Sparse requesters 2 and 7 from pointer 0.
        step(1'b1, 1'b0);
        eu_valid_i  = 9'b010000100;
        refill_mask = 9'b010000100;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);

        // Backpressure for 5 cycles, then release and drain.
        refill_mask = '1;
        rdy_pct     = 100;
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0);
        rdy_pct = 0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        rdy_pct = 100;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);

        // Fill the output stage, then flush with all EUs requesting.
        rdy_pct = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        eu_valid_i = '1;
        step(1'b0, 1'b1);
        rdy_pct = 100;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

        // Random traffic with occasional flush and reset.
        refill_pct = 40;
        rdy_pct    = 60;
        for (int i = 0; i < 2000; i++) begin
            if (i % 200 == 0) refill_mask = EU_N'($urandom) | EU_N'(1);
            step($urandom_range(999) < 5, $urandom_range(99) < 1);
        end

        // Drain and confirm nothing is left outstanding.
        refill_pct = 0;
        rdy_pct    = 100;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
        chk("drain_valid", 64'(cdb_valid_o), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
